// File: rtl/wb_arb_pkg.sv
// Shared constants and the pending-queue entry type for the register-file write arbiter.
package wb_arb_pkg;

   localparam int WB_AW    = 5;
   localparam int WB_DW    = 32;
   localparam int WB_DEPTH = 4;

   localparam logic [WB_AW-1:0] REG_ZERO = '0;

   typedef struct packed {
      logic             live;
      logic [WB_AW-1:0] wr;
      logic [WB_DW-1:0] wd;
   } wb_entry_t;

endpackage

// File: rtl/wb_write_arbiter_if.sv
// Pipeline writeback, late-result handshake and register-file write port of the arbiter.
interface wb_write_arbiter_if
   import wb_arb_pkg::*;
#(
   parameter int AW = WB_AW,
   parameter int DW = WB_DW
);

   logic          pl_valid;
   logic [AW-1:0] pl_wr;
   logic [DW-1:0] pl_wd;

   logic          lr_valid;
   logic          lr_ready;
   logic [AW-1:0] lr_wr;
   logic [DW-1:0] lr_wd;

   logic          rf_write;
   logic [AW-1:0] rf_wr;
   logic [DW-1:0] rf_wd;

   modport master (
      output pl_valid, pl_wr, pl_wd,
      output lr_valid, lr_wr, lr_wd,
      input  lr_ready,
      input  rf_write, rf_wr, rf_wd
   );

   modport slave (
      input  pl_valid, pl_wr, pl_wd,
      input  lr_valid, lr_wr, lr_wd,
      output lr_ready,
      output rf_write, rf_wr, rf_wd
   );

endinterface

// File: rtl/wb_pending_q.sv
// Circular pending queue for late results: storage, pointers, kill-by-address, age-ordered match vectors.
// WB_ARB_FWD_EN adds the age-ordered data view used for forwarding.
module wb_pending_q
   import wb_arb_pkg::*;
#(
   parameter  int DEPTH = WB_DEPTH,
   parameter  int AW    = WB_AW,
   parameter  int DW    = WB_DW,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      enq,
   input  logic [AW-1:0]             enq_wr,
   input  logic [DW-1:0]             enq_wd,
   input  logic                      deq,
   input  logic                      kill_en,
   input  logic [AW-1:0]             kill_wr,
   input  logic [AW-1:0]             pr1,
   input  logic [AW-1:0]             pr2,
   output logic [CW-1:0]             count,
   output wb_entry_t                 head,
`ifdef WB_ARB_FWD_EN
   output logic [DEPTH-1:0][DW-1:0]  age_wd,
`endif
   output logic [DEPTH-1:0]          match1,
   output logic [DEPTH-1:0]          match2
);

   wb_entry_t     q [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      end else begin
         // Kill first so a same-cycle enqueue of the same register survives as the newer value.
         for (int i = 0; i < DEPTH; i++)
            if (kill_en && q[i].live && (q[i].wr == kill_wr)) q[i].live <= 1'b0;
         if (deq) begin
            q[rd_ptr].live <= 1'b0;
            rd_ptr         <= rd_ptr + PW'(1);
         end
         if (enq) begin
            q[wr_ptr] <= '{live: 1'b1, wr: enq_wr, wd: enq_wd};
            wr_ptr    <= wr_ptr + PW'(1);
         end
         case ({enq, deq})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign head = q[rd_ptr];

   // Index a = age offset from the head, so higher a means younger.
   always_comb begin
      match1 = '0;
      match2 = '0;
`ifdef WB_ARB_FWD_EN
      age_wd = '0;
`endif
      for (int a = 0; a < DEPTH; a++) begin
         match1[a] = q[rd_ptr + PW'(a)].live && (q[rd_ptr + PW'(a)].wr == pr1) && (pr1 != REG_ZERO);
         match2[a] = q[rd_ptr + PW'(a)].live && (q[rd_ptr + PW'(a)].wr == pr2) && (pr2 != REG_ZERO);
`ifdef WB_ARB_FWD_EN
         age_wd[a] = q[rd_ptr + PW'(a)].wd;
`endif
      end
   end

endmodule

// File: rtl/wb_write_arbiter.sv
// Sole register-file writer: pipeline writebacks take the port, late results wait in a pending queue.
// WB_ARB_FWD_EN: forward youngest queued data to decode instead of stalling on it.
module wb_write_arbiter
   import wb_arb_pkg::*;
#(
   parameter  int DEPTH = WB_DEPTH,
   parameter  int AW    = WB_AW,
   parameter  int DW    = WB_DW,
   localparam int CW    = $clog2(DEPTH) + 1
) (
   input  logic                 clk,
   input  logic                 reset,
   wb_write_arbiter_if.slave    bus,
   input  logic [AW-1:0]        rd_pr1,
   input  logic [AW-1:0]        rd_pr2,
   output logic                 hz_stall,
   output logic                 fwd1_hit,
   output logic [DW-1:0]        fwd1_data,
   output logic                 fwd2_hit,
   output logic [DW-1:0]        fwd2_data,
   output logic [CW-1:0]        q_count
);

   logic [CW-1:0]            count;
   wb_entry_t                head;
   logic [DEPTH-1:0]         match1;
   logic [DEPTH-1:0]         match2;
`ifdef WB_ARB_FWD_EN
   logic [DEPTH-1:0][DW-1:0] age_wd;
`endif
   logic                     enq;
   logic                     deq;
   logic                     kill_en;
   logic                     head_wr;
   logic                     q_nonempty;

   assign q_nonempty   = (count != '0);
   // Ready comes from the registered count, so a full queue stays unready even while draining.
   assign bus.lr_ready = (count < CW'(DEPTH));
   assign enq          = bus.lr_valid && bus.lr_ready && (bus.lr_wr != REG_ZERO);
   assign kill_en      = bus.pl_valid && (bus.pl_wr != REG_ZERO);
   assign head_wr      = q_nonempty && head.live && !bus.pl_valid;
   // Dead heads are popped even under a pipeline write; they never need the port.
   assign deq          = q_nonempty && (!head.live || !bus.pl_valid);
   assign q_count      = count;

   wb_pending_q #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .DW    (DW)
   ) u_pq (
      .clk     (clk),
      .reset   (reset),
      .enq     (enq),
      .enq_wr  (bus.lr_wr),
      .enq_wd  (bus.lr_wd),
      .deq     (deq),
      .kill_en (kill_en),
      .kill_wr (bus.pl_wr),
      .pr1     (rd_pr1),
      .pr2     (rd_pr2),
      .count   (count),
      .head    (head),
`ifdef WB_ARB_FWD_EN
      .age_wd  (age_wd),
`endif
      .match1  (match1),
      .match2  (match2)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         bus.rf_write <= 1'b0;
         bus.rf_wr    <= '0;
         bus.rf_wd    <= '0;
      end else if (bus.pl_valid) begin
         bus.rf_write <= (bus.pl_wr != REG_ZERO);
         bus.rf_wr    <= bus.pl_wr;
         bus.rf_wd    <= bus.pl_wd;
      end else if (head_wr) begin
         bus.rf_write <= 1'b1;
         bus.rf_wr    <= head.wr;
         bus.rf_wd    <= head.wd;
      end else begin
         bus.rf_write <= 1'b0;
      end
   end

   always_comb begin
      hz_stall  = 1'b0;
      fwd1_hit  = 1'b0;
      fwd1_data = '0;
      fwd2_hit  = 1'b0;
      fwd2_data = '0;
`ifdef WB_ARB_FWD_EN
      // Ascending age: the last match seen is the youngest.
      for (int a = 0; a < DEPTH; a++) begin
         if (match1[a]) begin
            fwd1_hit  = 1'b1;
            fwd1_data = age_wd[a];
         end
         if (match2[a]) begin
            fwd2_hit  = 1'b1;
            fwd2_data = age_wd[a];
         end
      end
      hz_stall = (bus.lr_valid && (rd_pr1 != REG_ZERO) && (bus.lr_wr == rd_pr1)) ||
                 (bus.lr_valid && (rd_pr2 != REG_ZERO) && (bus.lr_wr == rd_pr2));
`else
      hz_stall = (|match1) || (|match2);
`endif
   end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter: expected rf writes are queued with their due cycle and
// checked by an independent monitor; WB_ARB_FWD_EN selects the forwarding expectations.
module tb_wb_write_arbiter;
   import wb_arb_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [4:0]  rd_pr1 = '0;
   logic [4:0]  rd_pr2 = '0;
   logic        hz_stall, fwd1_hit, fwd2_hit;
   logic [31:0] fwd1_data, fwd2_data;
   logic [2:0]  q_count;

   int cyc   = 0;
   int n_vec = 0;
   int n_err = 0;
   int d;

   typedef struct {
      logic [4:0]  wr;
      logic [31:0] wd;
      int          due;
   } exp_t;
   exp_t sb[$];
   exp_t mon_e;

   wb_write_arbiter_if bus ();

   wb_write_arbiter dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .rd_pr1    (rd_pr1),
      .rd_pr2    (rd_pr2),
      .hz_stall  (hz_stall),
      .fwd1_hit  (fwd1_hit),
      .fwd1_data (fwd1_data),
      .fwd2_hit  (fwd2_hit),
      .fwd2_data (fwd2_data),
      .q_count   (q_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every rf write must be the next expected one, at its expected cycle.
   always @(negedge clk) begin
      if (bus.rf_write === 1'b1) begin
         n_vec++;
         if (sb.size() == 0) begin
            n_err++;
            $display("FAIL rf_unexpected: got r%0d=%h at cyc %0d, expected no write", bus.rf_wr, bus.rf_wd, cyc);
         end else begin
            mon_e = sb.pop_front();
            if (bus.rf_wr !== mon_e.wr || bus.rf_wd !== mon_e.wd || cyc != mon_e.due) begin
               n_err++;
               $display("FAIL rf_write: got r%0d=%h at cyc %0d, expected r%0d=%h at cyc %0d",
                        bus.rf_wr, bus.rf_wd, cyc, mon_e.wr, mon_e.wd, mon_e.due);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cyc %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.pl_valid = 1'b0;
      bus.pl_wr    = '0;
      bus.pl_wd    = '0;
      bus.lr_valid = 1'b0;
      bus.lr_wr    = '0;
      bus.lr_wd    = '0;
   endtask

   // Pipeline write: lands on rf_* one cycle later unless the destination is r0.
   task automatic pl_set(input logic [4:0] wr, input logic [31:0] wd);
      bus.pl_valid = 1'b1;
      bus.pl_wr    = wr;
      bus.pl_wd    = wd;
      if (wr != 5'd0) sb.push_back('{wr: wr, wd: wd, due: cyc + 1});
   endtask

   task automatic lr_set(input logic [4:0] wr, input logic [31:0] wd);
      bus.lr_valid = 1'b1;
      bus.lr_wr    = wr;
      bus.lr_wd    = wd;
   endtask

   initial begin
      idle();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rf_write", {31'd0, bus.rf_write}, 32'd0);
      chk("rst_rf_wr", {27'd0, bus.rf_wr}, 32'd0);
      chk("rst_rf_wd", bus.rf_wd, 32'd0);
      chk("rst_q_count", {29'd0, q_count}, 32'd0);
      chk("rst_lr_ready", {31'd0, bus.lr_ready}, 32'd1);
      reset = 1'b0;
      tick();

      // Single pipeline writeback.
      pl_set(5'd3, 32'hA5);
      tick();
      idle();
      tick();

      // Late result r7=0x11 with decode reading r7 while it waits.
      rd_pr1 = 5'd7;
      lr_set(5'd7, 32'h11);
      sb.push_back('{wr: 5'd7, wd: 32'h11, due: cyc + 2});
      #1;
`ifdef WB_ARB_FWD_EN
      chk("lr_in_hz", {31'd0, hz_stall}, 32'd1);
`else
      chk("lr_in_hz", {31'd0, hz_stall}, 32'd0);
`endif
      tick();
      idle();
      #1;
      chk("lr_wait_q_count", {29'd0, q_count}, 32'd1);
`ifdef WB_ARB_FWD_EN
      chk("lr_wait_hz", {31'd0, hz_stall}, 32'd0);
      chk("lr_wait_fwd1_hit", {31'd0, fwd1_hit}, 32'd1);
      chk("lr_wait_fwd1_data", fwd1_data, 32'h11);
`else
      chk("lr_wait_hz", {31'd0, hz_stall}, 32'd1);
      chk("lr_wait_fwd1_hit", {31'd0, fwd1_hit}, 32'd0);
`endif
      tick();
      tick();
      rd_pr1 = 5'd0;

      // Fill the queue while the pipeline owns the port, then drain oldest-first.
      for (int k = 0; k < 4; k++) begin
         pl_set(5'd9, 32'h100 + k);
         lr_set(5'(10 + k), 32'hA0 + k);
         tick();
      end
      chk("full_q_count", {29'd0, q_count}, 32'd4);
      chk("full_lr_ready", {31'd0, bus.lr_ready}, 32'd0);
      pl_set(5'd9, 32'h104);
      lr_set(5'd14, 32'hEE);
      tick();
      chk("full_hold_q_count", {29'd0, q_count}, 32'd4);
      idle();
      d = cyc;
      for (int k = 0; k < 4; k++) sb.push_back('{wr: 5'(10 + k), wd: 32'hA0 + k, due: d + 1 + k});
      #1;
      chk("drain_lr_ready_0", {31'd0, bus.lr_ready}, 32'd0);
      tick();
      chk("drain_lr_ready_1", {31'd0, bus.lr_ready}, 32'd1);
      chk("drain_q_count", {29'd0, q_count}, 32'd3);
      repeat (4) tick();

      // WAW: a younger pipeline write to r5 kills the queued r5.
      pl_set(5'd9, 32'h200);
      lr_set(5'd5, 32'h22);
      tick();
      idle();
      pl_set(5'd5, 32'h33);
      rd_pr2 = 5'd5;
      #1;
      chk("waw_q_count", {29'd0, q_count}, 32'd1);
`ifdef WB_ARB_FWD_EN
      chk("waw_fwd2_hit", {31'd0, fwd2_hit}, 32'd1);
      chk("waw_fwd2_data", fwd2_data, 32'h22);
`else
      chk("waw_hz", {31'd0, hz_stall}, 32'd1);
`endif
      tick();
      idle();
      #1;
      chk("waw_dead_hz", {31'd0, hz_stall}, 32'd0);
      chk("waw_dead_fwd2", {31'd0, fwd2_hit}, 32'd0);
      tick();
      chk("waw_q_empty", {29'd0, q_count}, 32'd0);
      rd_pr2 = 5'd0;
      tick();

      // Register zero is never written nor queued, and never stalls.
      pl_set(5'd0, 32'hFF);
      lr_set(5'd0, 32'hEE);
      #1;
      chk("zero_hz", {31'd0, hz_stall}, 32'd0);
      tick();
      idle();
      chk("zero_rf_write", {31'd0, bus.rf_write}, 32'd0);
      chk("zero_q_count", {29'd0, q_count}, 32'd0);
      tick();

      // Reset with three entries queued discards them and blocks the pending pl write.
      for (int k = 0; k < 3; k++) begin
         pl_set(5'd9, 32'h300 + k);
         lr_set(5'(20 + k), 32'h1 + k);
         tick();
      end
      chk("pre_rst_q_count", {29'd0, q_count}, 32'd3);
      idle();
      reset        = 1'b1;
      bus.pl_valid = 1'b1;
      bus.pl_wr    = 5'd9;
      bus.pl_wd    = 32'h3FF;
      tick();
      chk("mid_rst_q_count", {29'd0, q_count}, 32'd0);
      chk("mid_rst_rf_write", {31'd0, bus.rf_write}, 32'd0);
      chk("mid_rst_lr_ready", {31'd0, bus.lr_ready}, 32'd1);
      reset = 1'b0;
      idle();
      repeat (6) tick();
      chk("post_rst_q_count", {29'd0, q_count}, 32'd0);

      repeat (3) tick();
      chk("sb_drained", sb.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
